// File: rtl/t02_mem_responder.sv
// rtl/t02_mem_responder.sv - Word-addressed memory responder with fixed access latency
//
// Purpose:
//   A single-port 32-bit memory behind a ren/wen request handshake. Each accepted
//   request spends LATENCY cycles in WAIT and then produces one DONE cycle.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, 2..1024)
//   LATENCY  WAIT cycles per access (1..15)
//
// Ports:
//   clk       rising-edge clock
//   nrst      asynchronous active-low reset
//   ren       read request, held until busy_o falls
//   wen       write request, held until busy_o falls
//   ramaddr   byte address; word index is ramaddr[log2(DEPTH)+1:2]
//   ramstore  write data
//   ramload   registered read data, held until the next completed read
//   busy_o    request accepted but not yet complete
//   err_o     illegal access flag, valid in the DONE cycle only
module t02_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic         op_write;
    logic         op_both;
    logic         op_bad;
    logic [AW-1:0] idx;
    logic [31:0]  wdata;
    logic [31:0]  mem [DEPTH];

    logic misaligned;
    logic out_of_range;

    assign misaligned   = |ramaddr[1:0];
    // Any set bit above the word-index field means ramaddr >= 4*DEPTH.
    assign out_of_range = |ramaddr[31:AW+2];

    // In IDLE the requester sees busy immediately, in the same cycle it asks.
    // Gated by nrst so busy stays low for the whole reset.
    always_comb begin
        busy_o = 1'b0;
        if (nrst) begin
            case (state)
                IDLE:    busy_o = ren | wen;
                WAIT:    busy_o = 1'b1;
                default: busy_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ramload  <= 32'h0;
            err_o    <= 1'b0;
            op_write <= 1'b0;
            op_both  <= 1'b0;
            op_bad   <= 1'b0;
            idx      <= '0;
            wdata    <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ren | wen) begin
                        // Write wins when both are requested; the clash is
                        // still reported through err_o.
                        op_write <= wen;
                        op_both  <= ren & wen;
                        op_bad   <= misaligned | out_of_range;
                        idx      <= ramaddr[AW+1:2];
                        wdata    <= ramstore;
                        cnt      <= 4'(LATENCY);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                        err_o <= op_bad | op_both;
                        if (op_bad) begin
                            // Illegal address: storage untouched, reads return zero.
                            if (!op_write) begin
                                ramload <= 32'h0;
                            end
                        end else if (op_write) begin
                            mem[idx] <= wdata;
                        end else begin
                            ramload <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    err_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t02_mem_responder.sv
// tb/tb_t02_mem_responder.sv - Directed self-checking bench for t02_mem_responder
module tb_t02_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk;
    logic        nrst;
    logic        ren;
    logic        wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    int n_cmp;
    int n_fail;

    t02_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .ren      (ren),
        .wen      (wen),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .busy_o   (busy_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at 1 time unit after a rising edge with the DUT in IDLE; returns
    // at 1 time unit after the edge that takes DONE back to IDLE.
    task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output int busy_cycles,
                             output logic [31:0] load, output logic err,
                             output bit done);
        busy_cycles = 0;
        load        = 32'hx;
        err         = 1'bx;
        done        = 1'b0;
        ren         = r;
        wen         = w;
        ramaddr     = a;
        ramstore    = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy_o) begin
                busy_cycles++;
            end else begin
                done = 1'b1;
                load = ramload;
                err  = err_o;
                ren  = 1'b0;
                wen  = 1'b0;
            end
        end
        ren = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst     = 1'b0;
        ren      = 1'b1;
        wen      = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        n_cmp++;
        if (ramload !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ramload: got %h expected 00000000", ramload);
        end
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err_o);
        end
        ren  = 1'b0;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_write_read();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        do_access(1'b0, 1'b1, 32'h10, 32'h1234_5678, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL write_10: done=%0d busy=%0d err=%b expected done=1 busy=3 err=0", dn, bc, er);
        end
        do_access(1'b1, 1'b0, 32'h10, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b0 || ld !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_10: done=%0d busy=%0d err=%b load=%h expected 1/3/0/12345678", dn, bc, er, ld);
        end
        // A write must leave ramload alone.
        do_access(1'b0, 1'b1, 32'h14, 32'h5555_AAAA, bc, ld, er, dn);
        n_cmp++;
        if (!dn || ld !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_holds_load: done=%0d load=%h expected 12345678", dn, ld);
        end
    endtask

    task automatic test_unwritten();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        do_access(1'b1, 1'b0, 32'h20, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b0 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_20: done=%0d busy=%0d err=%b load=%h expected 1/3/0/00000000", dn, bc, er, ld);
        end
    endtask

    task automatic test_both();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        do_access(1'b1, 1'b1, 32'h04, 32'hA5A5_A5A5, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b1 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL both_04: done=%0d busy=%0d err=%b load=%h expected 1/3/1/00000000", dn, bc, er, ld);
        end
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_after_done: got %b expected 0", err_o);
        end
        do_access(1'b1, 1'b0, 32'h04, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || er !== 1'b0 || ld !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL read_04: done=%0d err=%b load=%h expected 1/0/a5a5a5a5", dn, er, ld);
        end
    endtask

    task automatic test_illegal();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        do_access(1'b1, 1'b0, 32'h02, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b1 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_misaligned: done=%0d busy=%0d err=%b load=%h expected 1/3/1/00000000", dn, bc, er, ld);
        end
        do_access(1'b1, 1'b0, 32'h04, 32'h0, bc, ld, er, dn);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b1 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_oor: done=%0d busy=%0d err=%b load=%h expected 1/3/1/00000000", dn, bc, er, ld);
        end
        // Out-of-range write must not alias onto word 0.
        do_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL write_oor: done=%0d busy=%0d err=%b expected 1/3/1", dn, bc, er);
        end
        do_access(1'b1, 1'b0, 32'h00, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || er !== 1'b0 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_00: done=%0d err=%b load=%h expected 1/0/00000000", dn, er, ld);
        end
        // Highest legal word.
        do_access(1'b0, 1'b1, 32'hFC, 32'hCAFE_F00D, bc, ld, er, dn);
        do_access(1'b1, 1'b0, 32'hFC, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || er !== 1'b0 || ld !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL read_fc: done=%0d err=%b load=%h expected 1/0/cafef00d", dn, er, ld);
        end
    endtask

    task automatic test_reset_in_wait();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        ren      = 1'b0;
        wen      = 1'b1;
        ramaddr  = 32'h08;
        ramstore = 32'h8888_9999;
        @(posedge clk);         // accepted, WAIT cycle 1
        @(posedge clk);         // WAIT cycle 2
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || ramload !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_in_wait: busy=%b load=%h expected 0/00000000", busy_o, ramload);
        end
        wen = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: busy=%b err=%b expected 0/0", busy_o, err_o);
        end
        do_access(1'b1, 1'b0, 32'h08, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || bc != 3 || er !== 1'b0 || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_08: done=%0d busy=%0d err=%b load=%h expected 1/3/0/00000000", dn, bc, er, ld);
        end
        do_access(1'b1, 1'b0, 32'h10, 32'h0, bc, ld, er, dn);
        n_cmp++;
        if (!dn || ld !== 32'h0) begin
            n_fail++;
            $display("FAIL read_10_cleared: done=%0d load=%h expected 00000000", dn, ld);
        end
    endtask

    task automatic test_back_to_back();
        int          bc;
        logic [31:0] ld;
        logic        er;
        bit          dn;
        int          n_done;
        logic [11:0] pattern;
        logic [11:0] expect_pattern;
        do_access(1'b0, 1'b1, 32'h0C, 32'h600D_F00D, bc, ld, er, dn);
        expect_pattern = 12'b1110_1110_1110;
        n_done = 0;
        ren      = 1'b1;
        wen      = 1'b0;
        ramaddr  = 32'h0C;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pattern[11-i] = busy_o;
            if (!busy_o) begin
                n_done++;
                n_cmp++;
                if (ramload !== 32'h600D_F00D || err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_done_%0d: load=%h err=%b expected 600df00d/0", n_done, ramload, err_o);
                end
            end
        end
        ren = 1'b0;
        n_cmp++;
        if (pattern !== expect_pattern || n_done != 3) begin
            n_fail++;
            $display("FAIL b2b_pattern: got %b (%0d done) expected %b (3 done)", pattern, n_done, expect_pattern);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_write_read();
        test_unwritten();
        test_both();
        test_illegal();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
